atm_keypad_entry: RTL and testbench
===================================

// Module: atm_keypad_entry
// PURPOSE
//  Keypad front-end for the ATM controller. Collects decimal keypresses and assembles the PIN and withdrawal amount.
//  Presents them on the pin/valid/amount interface consumed by the ATM FSM.
//  Sits between the keypad scanner and fsm; it is the producer for that interface.
// PARAMETERS
//  VALID_CYCLES    2     cycles valid is held high per presentation (PIN, then amount)
//  PIN_DIGITS      2     max decimal digits accepted for PIN
//  AMT_DIGITS      3     max decimal digits accepted for amount
//  TIMEOUT_CYCLES  1000  inactivity limit in entry states (used only with ATM_ENTRY_TIMEOUT_EN)
// PORTS
//  clk         in   1   single clock, all logic on rising edge
//  reset       in   1   synchronous, active-high
//  card_in     in   1   card present; low forces IDLE from any state
//  key_strobe  in   1   one-cycle pulse, key_code valid
//  key_code    in   4   0x0-0x9 digit, 0xA ENTER, 0xB CLEAR, 0xC CANCEL, 0xD-0xF illegal
//  pin         out  5   assembled PIN to fsm
//  valid       out  1   presentation strobe to fsm
//  amount      out  8   assembled amount to fsm
//  busy        out  1   high in any state other than IDLE
//  key_err     out  1   one-cycle pulse on a rejected key or value
//  timeout     out  1   one-cycle pulse on inactivity abort (ATM_ENTRY_TIMEOUT_EN only; else tied 0)
// BEHAVIOUR
//  Reset: state=IDLE. pin, amount, valid, busy, key_err and timeout are all 0. Accumulator and digit count are cleared.
//  States:
//  - IDLE -> PIN_ENTRY when card_in=1.
//  - PIN_ENTRY -> PIN_SEND on ENTER.
//  - PIN_SEND -> AMT_ENTRY after VALID_CYCLES.
//  - AMT_ENTRY -> AMT_SEND on ENTER.
//  - AMT_SEND -> IDLE after VALID_CYCLES.
//  - Any state -> IDLE on card_in=0 or CANCEL. This clears pin, amount and valid on the next edge.
//  Digit key in an ENTRY state: acc <= acc*10 + digit; cnt++. Acc is 10 bits (max 999).
//  Digit with cnt == PIN_DIGITS (or AMT_DIGITS): digit is dropped and key_err pulses.
//  ENTER with cnt=0 is ignored (no key_err).
//  ENTER with PIN acc > 31 or amount acc > 255: key_err pulses; acc and cnt clear; state is unchanged.
//  CLEAR: acc and cnt clear; state is unchanged.
//  Illegal codes 0xD-0xF: key_err pulses; no other effect.
//  Accepted ENTER in PIN_ENTRY: pin <= acc[4:0], registered on the transition edge.
//  - valid=1 for exactly VALID_CYCLES cycles, starting the cycle after the ENTER edge.
//  - acc and cnt clear.
//  - pin stays stable until return to IDLE.
//  Amount follows the same rules: amount <= acc[7:0]; valid again for VALID_CYCLES.
//  - pin and amount are both held during AMT_SEND.
//  Latency: ENTER strobe to valid rising = 1 cycle.
//  key_strobe during PIN_SEND or AMT_SEND is ignored silently; keypresses are not queued.
//  CANCEL, or card_in falling, during SEND: valid drops on the next edge.
//  key_strobe in IDLE is ignored.
//  Reset mid-operation: returns to reset values on the next edge.
// CONFIGURATION
//  ATM_ENTRY_TIMEOUT_EN defined:
//  - A counter runs in PIN_ENTRY and AMT_ENTRY and reloads on every key_strobe.
//  - At TIMEOUT_CYCLES idle cycles: timeout pulses and the state goes to IDLE, clearing outputs.
//  Not defined: no counter; timeout is tied to 0; entry states wait indefinitely.
// STRUCTURE
//  atm_pkg holds:
//  - key code localparams: KEY_ENTER=4'hA, KEY_CLEAR=4'hB, KEY_CANCEL=4'hC;
//  - state encoding: IDLE, PIN_ENTRY, PIN_SEND, AMT_ENTRY, AMT_SEND;
//  - limits PIN_MAX=31, AMT_MAX=255.
//  Sub-module atm_bcd_accum: 10-bit decimal accumulator plus digit counter.
//  - Ports: clk, reset, clr, digit_en, digit, max_digits; outputs acc, cnt, overflow_digit.
//  - The top level holds the FSM, valid counter, output registers and optional timeout counter.
// TESTING
//  1. card_in=1; keys 2,6,ENTER -> pin=5'd26 (11010b); valid=1 for 2 cycles starting 1 cycle after ENTER; state=AMT_ENTRY.
//  2. Then keys 1,0,2,ENTER -> amount=8'd102 (0x66); valid=1 for 2 cycles; pin still 26; then IDLE, busy=0.
//  3. PIN keys 4,5,ENTER -> key_err pulse; no valid; still PIN_ENTRY; then 7,ENTER -> pin=7.
//  4. Amount keys 3,0,0,ENTER -> key_err; keys 1,2,3,4 -> key_err on the 4th digit; ENTER -> amount=123.
//  5. CANCEL mid-AMT_ENTRY, and separately card_in=0 during AMT_SEND -> IDLE next edge; valid, pin, amount=0.
//  6. With ATM_ENTRY_TIMEOUT_EN, TIMEOUT_CYCLES=20: no keys for 20 cycles in PIN_ENTRY -> timeout pulse, IDLE; without the macro -> stays in PIN_ENTRY.

Source files
------------

// File: rtl/atm_pkg.sv
// atm_pkg: shared definitions for the ATM keypad front-end.
// Holds key codes, the entry FSM state encoding and the PIN/amount value limits.
// No ports; imported by atm_bcd_accum and atm_keypad_entry.
package atm_pkg;

  // Keypad codes above the decimal digits.
  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  // Accumulator holds up to three decimal digits (max 999).
  localparam int ACC_W = 10;
  localparam int CNT_W = 2;

  // Largest values that fit the 5-bit PIN and 8-bit amount buses.
  localparam logic [ACC_W-1:0] PIN_MAX = 10'd31;
  localparam logic [ACC_W-1:0] AMT_MAX = 10'd255;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PIN_ENTRY = 3'd1,
    PIN_SEND  = 3'd2,
    AMT_ENTRY = 3'd3,
    AMT_SEND  = 3'd4
  } state_t;

endpackage

// File: rtl/atm_bcd_accum.sv
// atm_bcd_accum: decimal accumulator (acc = acc*10 + digit) with a digit counter.
// Ports: clk, reset (sync, active-high), clr, digit_en, digit[3:0], max_digits[1:0] in;
//        acc[9:0], cnt[1:0], overflow_digit (combinational: digit offered while full) out.
module atm_bcd_accum
  import atm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             digit_en,
  input  logic [3:0]       digit,
  input  logic [CNT_W-1:0] max_digits,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] cnt,
  output logic             overflow_digit
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full;

  // A digit is only ever accepted while cnt < 3, so acc <= 99 before the
  // multiply and the 10-bit result cannot wrap.
  always_comb begin
    full  = (cnt_q >= max_digits);
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (digit_en && !full) begin
      acc_d = acc_q * 10'd10 + {6'd0, digit};
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc            = acc_q;
  assign cnt            = cnt_q;
  assign overflow_digit = digit_en && full;

endmodule

// File: rtl/atm_keypad_entry.sv
// atm_keypad_entry: collects keypad digits into a PIN then an amount and presents
// each on pin/amount with valid held for VALID_CYCLES cycles (ENTER to valid = 1 cycle).
// Ports: clk, reset, card_in, key_strobe, key_code[3:0] in; pin[4:0], valid, amount[7:0],
//        busy, key_err, timeout out. Optional inactivity abort: define ATM_ENTRY_TIMEOUT_EN.
module atm_keypad_entry
  import atm_pkg::*;
#(
  parameter int VALID_CYCLES   = 2,
  parameter int PIN_DIGITS     = 2,
  parameter int AMT_DIGITS     = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       card_in,
  input  logic       key_strobe,
  input  logic [3:0] key_code,
  output logic [4:0] pin,
  output logic       valid,
  output logic [7:0] amount,
  output logic       busy,
  output logic       key_err,
  output logic       timeout
);

  localparam int VCNT_W = (VALID_CYCLES > 1) ? $clog2(VALID_CYCLES) : 1;

  state_t            state_q;
  logic [4:0]        pin_q;
  logic [7:0]        amount_q;
  logic              valid_q;
  logic              key_err_q;
  logic [VCNT_W-1:0] vcnt_q;

  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic              overflow_digit;

  logic              in_entry, key_live, is_digit, is_enter, is_clear, is_cancel, illegal;
  logic              digit_en, enter_ok, enter_bad, acc_clr, timeout_fire;
  logic [CNT_W-1:0]  max_digits;
  logic [ACC_W-1:0]  limit;

`ifdef ATM_ENTRY_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMR_W-1:0] tmr_q;
  logic             timeout_q;

  // Fires on the TIMEOUT_CYCLES-th consecutive entry-state cycle without a key.
  assign timeout_fire = in_entry && card_in && !key_strobe &&
                        (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
  assign timeout      = timeout_q;
`else
  assign timeout_fire = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_comb begin
    in_entry   = (state_q == PIN_ENTRY) || (state_q == AMT_ENTRY);
    is_digit   = (key_code <= 4'd9);
    is_enter   = (key_code == KEY_ENTER);
    is_clear   = (key_code == KEY_CLEAR);
    is_cancel  = (key_code == KEY_CANCEL);
    illegal    = (key_code >= 4'hD);
    max_digits = (state_q == PIN_ENTRY) ? CNT_W'(PIN_DIGITS) : CNT_W'(AMT_DIGITS);
    limit      = (state_q == PIN_ENTRY) ? PIN_MAX : AMT_MAX;
    // Keys only act in entry states with the card present; SEND and IDLE drop them.
    key_live   = key_strobe && card_in && in_entry;
    digit_en   = key_live && is_digit;
    enter_ok   = key_live && is_enter && (cnt != '0) && (acc <= limit);
    enter_bad  = key_live && is_enter && (cnt != '0) && (acc >  limit);
    // Accumulator is held clear outside entry states so each entry starts from zero.
    acc_clr    = !in_entry || !card_in || timeout_fire ||
                 (key_live && (is_clear || is_cancel || (is_enter && (cnt != '0))));
  end

  atm_bcd_accum u_accum (
    .clk            (clk),
    .reset          (reset),
    .clr            (acc_clr),
    .digit_en       (digit_en),
    .digit          (key_code),
    .max_digits     (max_digits),
    .acc            (acc),
    .cnt            (cnt),
    .overflow_digit (overflow_digit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pin_q     <= '0;
      amount_q  <= '0;
      valid_q   <= 1'b0;
      key_err_q <= 1'b0;
      vcnt_q    <= '0;
`ifdef ATM_ENTRY_TIMEOUT_EN
      tmr_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      key_err_q <= 1'b0;
`ifdef ATM_ENTRY_TIMEOUT_EN
      timeout_q <= 1'b0;
      tmr_q     <= (in_entry && !key_strobe) ? tmr_q + TMR_W'(1) : '0;
`endif
      if (!card_in || timeout_fire ||
          (key_strobe && is_cancel && (state_q != IDLE))) begin
        // Abort path: back to IDLE with all presented data cleared.
        state_q  <= IDLE;
        pin_q    <= '0;
        amount_q <= '0;
        valid_q  <= 1'b0;
        vcnt_q   <= '0;
`ifdef ATM_ENTRY_TIMEOUT_EN
        timeout_q <= timeout_fire;
        tmr_q     <= '0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= PIN_ENTRY;
          end
          PIN_ENTRY: begin
            if (key_live && (illegal || overflow_digit || enter_bad)) key_err_q <= 1'b1;
            if (enter_ok) begin
              pin_q   <= acc[4:0];
              valid_q <= 1'b1;
              vcnt_q  <= '0;
              state_q <= PIN_SEND;
            end
          end
          PIN_SEND: begin
            if (vcnt_q == VCNT_W'(VALID_CYCLES - 1)) begin
              valid_q <= 1'b0;
              vcnt_q  <= '0;
              state_q <= AMT_ENTRY;
            end else begin
              vcnt_q <= vcnt_q + VCNT_W'(1);
            end
          end
          AMT_ENTRY: begin
            if (key_live && (illegal || overflow_digit || enter_bad)) key_err_q <= 1'b1;
            if (enter_ok) begin
              amount_q <= acc[7:0];
              valid_q  <= 1'b1;
              vcnt_q   <= '0;
              state_q  <= AMT_SEND;
            end
          end
          AMT_SEND: begin
            if (vcnt_q == VCNT_W'(VALID_CYCLES - 1)) begin
              valid_q  <= 1'b0;
              vcnt_q   <= '0;
              pin_q    <= '0;
              amount_q <= '0;
              state_q  <= IDLE;
            end else begin
              vcnt_q <= vcnt_q + VCNT_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign pin     = pin_q;
  assign amount  = amount_q;
  assign valid   = valid_q;
  assign key_err = key_err_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_atm_keypad_entry.sv
module tb_atm_keypad_entry;
  import atm_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       card_in;
  logic       key_strobe;
  logic [3:0] key_code;
  logic [4:0] pin;
  logic       valid;
  logic [7:0] amount;
  logic       busy;
  logic       key_err;
  logic       timeout;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  atm_keypad_entry #(
    .VALID_CYCLES   (2),
    .PIN_DIGITS     (2),
    .AMT_DIGITS     (3),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .card_in    (card_in),
    .key_strobe (key_strobe),
    .key_code   (key_code),
    .pin        (pin),
    .valid      (valid),
    .amount     (amount),
    .busy       (busy),
    .key_err    (key_err),
    .timeout    (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle key strobe; returns 1 unit after the edge that sampled it.
  task automatic press(input logic [3:0] code);
    key_strobe = 1'b1;
    key_code   = code;
    tick();
    key_strobe = 1'b0;
    key_code   = 4'h0;
  endtask

  initial begin
    reset      = 1'b1;
    card_in    = 1'b0;
    key_strobe = 1'b0;
    key_code   = 4'h0;
    repeat (3) tick();

    // Reset state
    chk("rst_pin",     32'(pin),     32'd0);
    chk("rst_amount",  32'(amount),  32'd0);
    chk("rst_valid",   32'(valid),   32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_key_err", 32'(key_err), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);

    reset   = 1'b0;
    card_in = 1'b1;
    tick();
    chk("t1_busy_pin_entry", 32'(dut.state_q), 32'(PIN_ENTRY));

    // 1: PIN 26
    press(4'd2);
    press(4'd6);
    chk("t1_valid_before_enter", 32'(valid), 32'd0);
    press(KEY_ENTER);
    chk("t1_valid_c1", 32'(valid), 32'd1);
    chk("t1_pin",      32'(pin),   32'd26);
    tick();
    chk("t1_valid_c2", 32'(valid), 32'd1);
    tick();
    chk("t1_valid_c3", 32'(valid), 32'd0);
    chk("t1_state",    32'(dut.state_q), 32'(AMT_ENTRY));

    // 2: amount 102
    press(4'd1);
    press(4'd0);
    press(4'd2);
    press(KEY_ENTER);
    chk("t2_valid_c1", 32'(valid),  32'd1);
    chk("t2_amount",   32'(amount), 32'd102);
    chk("t2_pin_held", 32'(pin),    32'd26);
    tick();
    chk("t2_valid_c2", 32'(valid),  32'd1);
    chk("t2_busy_c2",  32'(busy),   32'd1);
    tick();
    chk("t2_valid_c3", 32'(valid),  32'd0);
    chk("t2_busy_idle", 32'(busy),  32'd0);

    // 3: PIN too large, illegal code, then PIN 7
    tick();
    chk("t3_busy", 32'(busy), 32'd1);
    press(4'hE);
    chk("t3_illegal_err", 32'(key_err), 32'd1);
    press(4'd4);
    chk("t3_err_cleared", 32'(key_err), 32'd0);
    press(4'd5);
    press(KEY_ENTER);
    chk("t3_big_pin_err",   32'(key_err), 32'd1);
    chk("t3_big_pin_valid", 32'(valid),   32'd0);
    chk("t3_state",         32'(dut.state_q), 32'(PIN_ENTRY));
    press(4'd7);
    press(KEY_ENTER);
    chk("t3_valid", 32'(valid), 32'd1);
    chk("t3_pin",   32'(pin),   32'd7);
    tick();
    tick();

    // 4: amount too large, digit overflow, then 123
    press(4'd3);
    press(4'd0);
    press(4'd0);
    press(KEY_ENTER);
    chk("t4_big_amt_err",   32'(key_err), 32'd1);
    chk("t4_big_amt_valid", 32'(valid),   32'd0);
    press(4'd1);
    press(4'd2);
    press(4'd3);
    chk("t4_third_digit_ok", 32'(key_err), 32'd0);
    press(4'd4);
    chk("t4_fourth_digit_err", 32'(key_err), 32'd1);
    press(KEY_ENTER);
    chk("t4_valid",  32'(valid),  32'd1);
    chk("t4_amount", 32'(amount), 32'd123);
    tick();
    tick();
    chk("t4_idle", 32'(busy), 32'd0);

    // 5a: CANCEL during amount entry
    tick();
    press(4'd9);
    press(KEY_ENTER);
    chk("t5a_pin", 32'(pin), 32'd9);
    tick();
    tick();
    press(4'd5);
    press(KEY_CANCEL);
    chk("t5a_busy",   32'(busy),   32'd0);
    chk("t5a_pin",    32'(pin),    32'd0);
    chk("t5a_amount", 32'(amount), 32'd0);
    chk("t5a_valid",  32'(valid),  32'd0);

    // 5b: CLEAR then empty ENTER, then card pulled during AMT_SEND
    tick();
    press(4'd2);
    press(KEY_CLEAR);
    press(KEY_ENTER);
    chk("t5b_empty_enter_valid", 32'(valid),   32'd0);
    chk("t5b_empty_enter_err",   32'(key_err), 32'd0);
    chk("t5b_still_pin_entry",   32'(dut.state_q), 32'(PIN_ENTRY));
    press(4'd3);
    press(KEY_ENTER);
    chk("t5b_pin_after_clear", 32'(pin), 32'd3);
    tick();
    tick();
    press(4'd8);
    press(KEY_ENTER);
    chk("t5b_amount", 32'(amount), 32'd8);
    card_in = 1'b0;
    tick();
    chk("t5b_valid_drop", 32'(valid),  32'd0);
    chk("t5b_pin_clr",    32'(pin),    32'd0);
    chk("t5b_amount_clr", 32'(amount), 32'd0);
    chk("t5b_busy",       32'(busy),   32'd0);

    // 6: inactivity in PIN_ENTRY
    card_in = 1'b1;
    tick();
    chk("t6_enter", 32'(dut.state_q), 32'(PIN_ENTRY));
`ifdef ATM_ENTRY_TIMEOUT_EN
    repeat (19) tick();
    chk("t6_no_timeout_yet", 32'(timeout), 32'd0);
    chk("t6_busy_before",    32'(busy),    32'd1);
    tick();
    chk("t6_timeout_pulse", 32'(timeout), 32'd1);
    chk("t6_idle",          32'(busy),    32'd0);
    tick();
    chk("t6_timeout_end", 32'(timeout), 32'd0);
`else
    repeat (25) tick();
    chk("t6_no_timeout", 32'(timeout), 32'd0);
    chk("t6_waits",      32'(dut.state_q), 32'(PIN_ENTRY));
`endif

    // Reset mid-operation
    tick();
    press(4'd1);
    press(4'd2);
    press(KEY_ENTER);
    chk("rst_mid_valid_pre", 32'(valid), 32'd1);
    reset = 1'b1;
    tick();
    chk("rst_mid_valid", 32'(valid), 32'd0);
    chk("rst_mid_pin",   32'(pin),   32'd0);
    chk("rst_mid_busy",  32'(busy),  32'd0);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
